// File: rtl/vec_state_mover.sv
// Sequences 128-bit block writes/reads onto the vector register file's single write / dual read port.
// Latency: write = 4 beats then wr_done; row read = 2 beats, column read = 4 beats, then response.
// Backpressure: cmd_ready only in IDLE; the response is held in RESP until rsp_ready.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op (0 wr, 1 rd), cmd_col (1 = column-major),
//                              cmd_base (first row of group), cmd_data (word i = [127-32i -: 32])
//   rsp_valid/rsp_ready        read response handshake, rsp_data same word order as cmd_data
//   wr_done                    one-cycle pulse after the last write beat
//   busy                       engine not idle
//   fila1, fila2, columna,     register file selects / write data / controls
//   data_in1, wr_en, col_read, col_write
//   data_out1, data_out2       register file read data (combinational from selects)
module vec_state_mover (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic         cmd_col,
  input  logic [3:0]   cmd_base,
  input  logic [127:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         wr_done,
  output logic         busy,
  output logic [3:0]   fila1,
  output logic [3:0]   fila2,
  output logic [1:0]   columna,
  output logic [31:0]  data_in1,
  output logic         wr_en,
  output logic         col_read,
  output logic         col_write,
  input  logic [31:0]  data_out1,
  input  logic [31:0]  data_out2
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD_ROW = 3'd2,
    S_RD_COL = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic           col_q;
  logic [3:0]     base_q;
  logic [127:0]   data_q;
  logic [127:0]   rsp_q;
  logic           wr_done_q;
  logic           accept;

  // In the non-reset branch rst_n is 1, so this equals the handshake.
  assign accept = cmd_valid && (state_q == S_IDLE);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= 2'd0;
      col_q     <= 1'b0;
      base_q    <= 4'd0;
      data_q    <= '0;
      rsp_q     <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wr_done_q <= (state_q == S_WR) && (beat_q == 2'd3);
      if (accept) begin
        col_q  <= cmd_col;
        base_q <= cmd_base;
        data_q <= cmd_data;
      end
      // Read data is captured at the closing edge of each beat.
      if (state_q == S_RD_ROW) begin
        if (beat_q[0] == 1'b0) begin
          rsp_q[127:96] <= data_out1;
          rsp_q[95:64]  <= data_out2;
        end else begin
          rsp_q[63:32]  <= data_out1;
          rsp_q[31:0]   <= data_out2;
        end
      end
      if (state_q == S_RD_COL) begin
        case (beat_q)
          2'd0:    rsp_q[127:96] <= data_out1;
          2'd1:    rsp_q[95:64]  <= data_out1;
          2'd2:    rsp_q[63:32]  <= data_out1;
          default: rsp_q[31:0]   <= data_out1;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_op)      state_d = S_WR;
          else if (cmd_col) state_d = S_RD_COL;
          else              state_d = S_RD_ROW;
        end
      end
      S_WR:     if (beat_q == 2'd3) state_d = S_IDLE;
      S_RD_ROW: if (beat_q == 2'd1) state_d = S_RESP;
      S_RD_COL: if (beat_q == 2'd3) state_d = S_RESP;
      S_RESP:   if (rsp_ready)      state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Beat counter restarts on every state change.
    beat_d = (state_d != state_q) ? 2'd0 : beat_q + 2'd1;
  end

  // ---------------------------------------------------------------------------
  // Output decode from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = rst_n && (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_data  = rsp_q;
    wr_done   = wr_done_q;
    fila1     = 4'd0;
    fila2     = 4'd0;
    columna   = 2'd0;
    data_in1  = 32'd0;
    wr_en     = 1'b0;
    col_read  = 1'b0;
    col_write = 1'b0;
    case (state_q)
      S_WR: begin
        // Gated by rst_n so a beat caught by reset never lands in the file.
        wr_en     = rst_n;
        col_write = col_q;
        fila1     = col_q ? base_q : base_q + {2'b00, beat_q};
        columna   = col_q ? beat_q : 2'd0;
        case (beat_q)
          2'd0:    data_in1 = data_q[127:96];
          2'd1:    data_in1 = data_q[95:64];
          2'd2:    data_in1 = data_q[63:32];
          default: data_in1 = data_q[31:0];
        endcase
      end
      S_RD_ROW: begin
        fila1 = base_q + {2'b00, beat_q[0], 1'b0};
        fila2 = base_q + {2'b00, beat_q[0], 1'b1};
      end
      S_RD_COL: begin
        col_read = 1'b1;
        fila1    = base_q;
        columna  = beat_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vec_state_mover.sv
module tb_vec_state_mover;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic         cmd_col;
  logic [3:0]   cmd_base;
  logic [127:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         wr_done;
  logic         busy;
  logic [3:0]   fila1, fila2;
  logic [1:0]   columna;
  logic [31:0]  data_in1;
  logic         wr_en, col_read, col_write;
  logic [31:0]  data_out1, data_out2;

  vec_state_mover dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_col(cmd_col),
    .cmd_base(cmd_base), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .wr_done(wr_done), .busy(busy),
    .fila1(fila1), .fila2(fila2), .columna(columna), .data_in1(data_in1),
    .wr_en(wr_en), .col_read(col_read), .col_write(col_write),
    .data_out1(data_out1), .data_out2(data_out2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: 16 x 32-bit rows, byte c of a row is column c.
  logic [31:0] mem [16];
  logic        rf_init;

  always @(posedge clk) begin
    if (rf_init) begin
      for (int r = 0; r < 16; r++) mem[r] <= 32'd0;
    end else if (wr_en) begin
      if (col_write) begin
        for (int k = 0; k < 4; k++) begin
          logic [3:0]  ra;
          logic [7:0]  b;
          logic [4:0]  sh;
          ra = fila1 + 4'(k);
          b  = 8'(data_in1 >> (24 - 8 * k));
          sh = 5'(24 - 8 * int'(columna));
          mem[ra] <= (mem[ra] & ~(32'hFF << sh)) | (32'(b) << sh);
        end
      end else begin
        mem[fila1] <= data_in1;
      end
    end
  end

  always_comb begin
    logic [31:0] cw;
    logic [3:0]  ra;
    cw = 32'd0;
    ra = 4'd0;
    for (int k = 0; k < 4; k++) begin
      ra = fila1 + 4'(k);
      cw = (cw << 8) | 32'(8'(mem[ra] >> (24 - 8 * int'(columna))));
    end
    data_out1 = col_read ? cw : mem[fila1];
    data_out2 = mem[fila2];
  end

  // Scoreboard state
  int checks   = 0;
  int failures = 0;
  logic [127:0] rsp_exp_q [$];
  int           wr_exp_q  [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] d, input int i);
    return 32'(d >> (96 - 32 * i));
  endfunction

  // Monitor: pops expected responses / write completions as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n && wr_done) begin
      if (wr_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_done_unexpected actual=1 required=0 cycle=%0d", cyc);
      end else begin
        int e;
        e = wr_exp_q.pop_front();
        chk("wr_done_cycle", 128'(cyc), 128'(e));
        chk("wr_done_cmd_ready", 128'(cmd_ready), 128'(1));
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rsp_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected actual=%h required=none", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, rsp_exp_q.pop_front());
      end
    end
  end

  // Drives a command from posedge+1 and waits for it to be taken; returns in cycle 1.
  task automatic issue(input logic op, input logic col, input logic [3:0] base,
                       input logic [127:0] d, output int waits, output bit acc);
    cmd_op = op; cmd_col = col; cmd_base = base; cmd_data = d; cmd_valid = 1'b1;
    acc = 1'b0; waits = 0;
    while (!acc && waits < 20) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic do_write(input logic col, input logic [3:0] base, input logic [127:0] d,
                          input bit imm);
    int waits; bit acc;
    issue(1'b0, col, base, d, waits, acc);
    if (!acc) return;
    if (imm) chk("b2b_accept_waits", 128'(waits), 128'(0));
    wr_exp_q.push_back(cyc + 4);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ef;
      ef = col ? base : base + 4'(k);
      @(negedge clk);
      chk("wr_en", 128'(wr_en), 128'(1));
      chk("wr_col_write", 128'(col_write), 128'(col));
      chk("wr_fila1", 128'(fila1), 128'(ef));
      chk("wr_columna", 128'(columna), col ? 128'(k) : 128'(0));
      chk("wr_data_in1", 128'(data_in1), 128'(word_of(d, k)));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_read(input logic col, input logic [3:0] base, input logic [127:0] exp,
                         input int stall);
    int waits; bit acc; bit got; int k;
    issue(1'b1, col, base, 128'd0, waits, acc);
    if (!acc) return;
    got = 1'b0; k = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (!col && k <= 2) begin
        logic [3:0] e1, e2;
        e1 = base + 4'(2 * (k - 1));
        e2 = base + 4'(2 * (k - 1) + 1);
        chk("rd_row_fila1", 128'(fila1), 128'(e1));
        chk("rd_row_fila2", 128'(fila2), 128'(e2));
        chk("rd_row_col_read", 128'(col_read), 128'(0));
      end
      if (col && k <= 4) begin
        chk("rd_col_fila1", 128'(fila1), 128'(base));
        chk("rd_col_columna", 128'(columna), 128'(k - 1));
        chk("rd_col_col_read", 128'(col_read), 128'(1));
      end
      if (rsp_valid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL rsp_timeout actual=no_rsp_valid required=rsp_valid");
      return;
    end
    chk("rsp_latency", 128'(k), col ? 128'(5) : 128'(3));
    rsp_exp_q.push_back(exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      // A write offered while the response is pending must be ignored.
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_col = 1'b0; cmd_base = base; cmd_data = ~exp;
      @(negedge clk);
      chk("stall_rsp_valid", 128'(rsp_valid), 128'(1));
      chk("stall_rsp_data", rsp_data, exp);
      chk("stall_cmd_ready", 128'(cmd_ready), 128'(0));
      chk("stall_wr_en", 128'(wr_en), 128'(0));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("post_rsp_rsp_valid", 128'(rsp_valid), 128'(0));
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] D  = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] T  = 128'h0105090D_02060A0E_03070B0F_04080C10;
  localparam logic [127:0] D2 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [127:0] T2 = 128'h115599DD_2266AAEE_3377BBFF_4488CC00;
  localparam logic [127:0] D3 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits; bit acc;
    rst_n = 1'b0; rf_init = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_col = 1'b0; cmd_base = 4'd0; cmd_data = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("reset_status", 128'({busy, rsp_valid, wr_done}), 128'(0));
    chk("reset_rsp_data", rsp_data, 128'd0);
    chk("reset_rf_outputs",
        128'({fila1, fila2, columna, data_in1, wr_en, col_read, col_write}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; rf_init = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
    @(posedge clk); #1;

    // Row-major write, then row and column reads of the same group.
    do_write(1'b0, 4'd0, D, 1'b0);
    @(negedge clk);
    chk("mem0", 128'(mem[0]), 128'(32'h01020304));
    chk("mem1", 128'(mem[1]), 128'(32'h05060708));
    chk("mem2", 128'(mem[2]), 128'(32'h090A0B0C));
    chk("mem3", 128'(mem[3]), 128'(32'h0D0E0F10));
    @(posedge clk); #1;
    do_read(1'b0, 4'd0, D, 0);
    do_read(1'b1, 4'd0, T, 0);

    // Column-major write then row read gives the transpose.
    do_write(1'b1, 4'd0, D, 1'b0);
    @(negedge clk);
    chk("colwr_mem0", 128'(mem[0]), 128'(32'h0105090D));
    chk("colwr_mem3", 128'(mem[3]), 128'(32'h04080C10));
    @(posedge clk); #1;
    do_read(1'b0, 4'd0, T, 0);

    // Row address wrap 14,15,0,1; read back with a 10-cycle response stall.
    do_write(1'b0, 4'd14, D, 1'b0);
    @(negedge clk);
    chk("wrap_mem14", 128'(mem[14]), 128'(32'h01020304));
    chk("wrap_mem15", 128'(mem[15]), 128'(32'h05060708));
    chk("wrap_mem0",  128'(mem[0]),  128'(32'h090A0B0C));
    chk("wrap_mem1",  128'(mem[1]),  128'(32'h0D0E0F10));
    @(posedge clk); #1;
    do_read(1'b0, 4'd14, D, 10);

    // Back-to-back writes: second one offered in the wr_done cycle.
    do_write(1'b0, 4'd8, D2, 1'b0);
    do_write(1'b0, 4'd12, D3, 1'b1);
    do_read(1'b1, 4'd8, T2, 0);
    do_read(1'b0, 4'd12, D3, 0);

    // Reset during write beat 2: only the first two rows land.
    issue(1'b0, 1'b0, 4'd4, D2, waits, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd_ready", 128'(cmd_ready), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_wr_en", 128'(wr_en), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_wr_done", 128'(wr_done), 128'(0));
    chk("rst_mid_rf", 128'({fila1, data_in1, col_write}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem4", 128'(mem[4]), 128'(32'h11223344));
    chk("rst_mem5", 128'(mem[5]), 128'(32'h55667788));
    chk("rst_mem6", 128'(mem[6]), 128'(32'h00000000));
    chk("rst_mem7", 128'(mem[7]), 128'(32'h00000000));
    @(posedge clk); #1;
    do_read(1'b0, 4'd4, 128'h11223344_55667788_00000000_00000000, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_queue_empty", 128'(rsp_exp_q.size()), 128'(0));
    chk("wr_queue_empty", 128'(wr_exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
